// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: measures hsync/vsync cadence, locks onto a
// conforming 800x525-style source and recovers pixel coordinates once locked.
module vga_sync_monitor #(
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_ACTIVE    = 640,
    parameter int H_FRONT     = 16,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_ACTIVE    = 480,
    parameter int V_FRONT     = 10,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk_50,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        hs_in,
    input  logic        vs_in,
    output logic        locked,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        in_display_area,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines,
    output logic [7:0]  err_cnt
);

    localparam int H_TOTAL  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int H_VIS_LO = H_SYNC + H_BACK;
    localparam int H_VIS_HI = H_VIS_LO + H_ACTIVE - 1;
    localparam int V_VIS_LO = V_SYNC + V_BACK;
    localparam int V_VIS_HI = V_VIS_LO + V_ACTIVE - 1;

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic        hs_s_q, hs_s_d, hs_d_q, hs_d_d;
    logic        vs_s_q, vs_s_d, vs_d_q, vs_d_d;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        pend_q, pend_d;
    logic        line_bad_q, line_bad_d;
    logic [7:0]  good_q, good_d;
    logic [1:0]  state_q, state_d;
    logic [10:0] line_len_q, line_len_d;
    logic [9:0]  frame_lines_q, frame_lines_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        hfall, vfall, frame_start;
    logic        line_ok, frame_ok, overrun, lock_err;
    logic [10:0] v_cnt_p1;
    logic [10:0] x_off;
    logic [9:0]  y_off;

    assign hfall       = hs_d_q & ~hs_s_q;
    assign vfall       = vs_d_q & ~vs_s_q;
    // A pending vsync, or one falling on this very tick, makes this hfall the frame start.
    assign frame_start = hfall & (pend_q | vfall);
    assign line_ok     = (h_cnt_q == 11'(H_TOTAL));
    assign v_cnt_p1    = {1'b0, v_cnt_q} + 11'd1;
    assign frame_ok    = (v_cnt_p1 == 11'(V_TOTAL)) & ~line_bad_q & line_ok;
    assign overrun     = (h_cnt_q > 11'(H_TOTAL));
    assign lock_err    = (hfall & ~line_ok) | (frame_start & ~frame_ok) | overrun;

    always_comb begin
        hs_s_d        = hs_s_q;
        hs_d_d        = hs_d_q;
        vs_s_d        = vs_s_q;
        vs_d_d        = vs_d_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        pend_d        = pend_q;
        line_bad_d    = line_bad_q;
        good_d        = good_q;
        state_d       = state_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        err_cnt_d     = err_cnt_q;

        if (pix_en) begin
            hs_s_d = hs_in;
            hs_d_d = hs_s_q;
            vs_s_d = vs_in;
            vs_d_d = vs_s_q;

            if (hfall) begin
                line_len_d = h_cnt_q;
                h_cnt_d    = 11'd1;
            end else begin
                h_cnt_d = sat_inc11(h_cnt_q);
            end

            if (frame_start) begin
                frame_lines_d = v_cnt_p1[9:0];
                v_cnt_d       = '0;
                pend_d        = 1'b0;
                line_bad_d    = 1'b0;
            end else begin
                if (vfall)
                    pend_d = 1'b1;
                if (hfall) begin
                    v_cnt_d = sat_inc10(v_cnt_q);
                    if (!line_ok)
                        line_bad_d = 1'b1;
                end
            end

            case (state_q)
                ST_SEARCH: begin
                    if (frame_start) begin
                        state_d = ST_VERIFY;
                        good_d  = '0;
                    end
                end
                ST_VERIFY: begin
                    if (frame_start) begin
                        if (!frame_ok) begin
                            good_d = '0;
                        end else if (good_q + 8'd1 == 8'(LOCK_FRAMES)) begin
                            state_d = ST_LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + 8'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Several simultaneous faults still count as one loss-of-lock event.
                    if (lock_err) begin
                        state_d   = ST_SEARCH;
                        err_cnt_d = sat_inc8(err_cnt_q);
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            hs_s_q        <= 1'b1;
            hs_d_q        <= 1'b1;
            vs_s_q        <= 1'b1;
            vs_d_q        <= 1'b1;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pend_q        <= 1'b0;
            line_bad_q    <= 1'b0;
            good_q        <= '0;
            state_q       <= ST_SEARCH;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            err_cnt_q     <= '0;
        end else begin
            hs_s_q        <= hs_s_d;
            hs_d_q        <= hs_d_d;
            vs_s_q        <= vs_s_d;
            vs_d_q        <= vs_d_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pend_q        <= pend_d;
            line_bad_q    <= line_bad_d;
            good_q        <= good_d;
            state_q       <= state_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign x_off = h_cnt_q - 11'(H_VIS_LO);
    assign y_off = v_cnt_q - 10'(V_VIS_LO);

    assign locked          = (state_q == ST_LOCKED);
    assign pixel_x         = locked ? x_off[9:0] : 10'd0;
    assign pixel_y         = locked ? y_off : 10'd0;
    assign in_display_area = locked
                           & (h_cnt_q >= 11'(H_VIS_LO)) & (h_cnt_q <= 11'(H_VIS_HI))
                           & (v_cnt_q >= 10'(V_VIS_LO)) & (v_cnt_q <= 10'(V_VIS_HI));
    assign line_len        = line_len_q;
    assign frame_lines     = frame_lines_q;
    assign err_cnt         = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a shrunken 17x9 timing so full
// lock sequences fit in a short run; expected tick numbers are hand-derived.
module tb_vga_sync_monitor;

    localparam int TB_HS = 4;
    localparam int TB_HB = 3;
    localparam int TB_HA = 8;
    localparam int TB_HF = 2;
    localparam int TB_VS = 2;
    localparam int TB_VB = 2;
    localparam int TB_VA = 4;
    localparam int TB_VF = 1;
    localparam int HT    = TB_HS + TB_HB + TB_HA + TB_HF;
    localparam int VT    = TB_VS + TB_VB + TB_VA + TB_VF;

    logic        clk_50 = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic        hs_in = 1'b1;
    logic        vs_in = 1'b1;
    logic        locked;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        in_display_area;
    logic [10:0] line_len;
    logic [9:0]  frame_lines;
    logic [7:0]  err_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Source model state
    int sh = 0, sv = 0, tick_n = 0;
    int ht_len = HT, vt_len = VT;
    bit hs_force = 1'b0;
    int disp_cnt = 0, run_len = 0, runs = 0, bad_runs = 0;

    vga_sync_monitor #(
        .H_SYNC(TB_HS), .H_BACK(TB_HB), .H_ACTIVE(TB_HA), .H_FRONT(TB_HF),
        .V_SYNC(TB_VS), .V_BACK(TB_VB), .V_ACTIVE(TB_VA), .V_FRONT(TB_VF),
        .LOCK_FRAMES(2)
    ) dut (
        .clk_50          (clk_50),
        .rst             (rst),
        .pix_en          (pix_en),
        .hs_in           (hs_in),
        .vs_in           (vs_in),
        .locked          (locked),
        .pixel_x         (pixel_x),
        .pixel_y         (pixel_y),
        .in_display_area (in_display_area),
        .line_len        (line_len),
        .frame_lines     (frame_lines),
        .err_cnt         (err_cnt)
    );

    always #10 clk_50 = ~clk_50;

    initial begin
        #1ms;
        $display("FAIL timeout: bench did not complete in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One pixel tick followed by an idle clock; outputs sampled on the falling edge.
    task automatic src_tick();
        @(negedge clk_50);
        hs_in  = (hs_force || sh >= TB_HS) ? 1'b1 : 1'b0;
        vs_in  = (sv >= TB_VS) ? 1'b1 : 1'b0;
        pix_en = 1'b1;
        @(negedge clk_50);
        pix_en = 1'b0;
        if (in_display_area) begin
            disp_cnt++;
            run_len++;
        end else if (run_len != 0) begin
            runs++;
            if (run_len != TB_HA) bad_runs++;
            run_len = 0;
        end
        sh++;
        if (sh == ht_len) begin
            sh     = 0;
            ht_len = HT;
            sv++;
            if (sv == vt_len) begin
                sv     = 0;
                vt_len = VT;
            end
        end
        tick_n++;
    endtask

    task automatic run_to(input int n);
        while (tick_n < n) src_tick();
    endtask

    initial begin
        repeat (3) @(negedge clk_50);
        rst = 1'b0;
        @(negedge clk_50);
        chk("reset_locked",   32'(locked), 0);
        chk("reset_pixel_x",  32'(pixel_x), 0);
        chk("reset_pixel_y",  32'(pixel_y), 0);
        chk("reset_in_disp",  32'(in_display_area), 0);
        chk("reset_line_len", 32'(line_len), 0);
        chk("reset_frame_ln", 32'(frame_lines), 0);
        chk("reset_err_cnt",  32'(err_cnt), 0);

        // Ideal source: frame starts at ticks 1, 154, 307; lock at 307
        run_to(307);
        chk("A_prelock_locked", 32'(locked), 0);
        chk("A_prelock_px_gated", 32'(pixel_x), 0);
        chk("A_line_len", 32'(line_len), 17);
        chk("A_frame_lines", 32'(frame_lines), 9);
        run_to(308);
        chk("A_lock_rise", 32'(locked), 1);
        chk("A_err_zero", 32'(err_cnt), 0);
        chk("A_px_trunc", 32'(pixel_x), 1018);
        disp_cnt = 0; run_len = 0; runs = 0; bad_runs = 0;
        run_to(381);
        chk("A_before_vis", 32'(in_display_area), 0);
        run_to(382);
        chk("A_first_vis", 32'(in_display_area), 1);
        chk("A_first_px", 32'(pixel_x), 0);
        chk("A_first_py", 32'(pixel_y), 0);
        repeat (40) @(negedge clk_50);
        chk("A_idle_hold_px", 32'(pixel_x), 0);
        chk("A_idle_hold_vis", 32'(in_display_area), 1);
        chk("A_idle_hold_locked", 32'(locked), 1);
        run_to(440);
        chk("A_last_vis", 32'(in_display_area), 1);
        chk("A_last_px", 32'(pixel_x), 7);
        chk("A_last_py", 32'(pixel_y), 3);
        run_to(441);
        chk("A_after_vis", 32'(in_display_area), 0);
        run_to(460);
        chk("A_vis_total", 32'(disp_cnt), 32);
        chk("A_vis_runs", 32'(runs), 4);
        chk("A_vis_bad_runs", 32'(bad_runs), 0);

        // One 18-tick line while locked; hfall at 495
        run_to(476);
        ht_len = 18;
        run_to(495);
        chk("B_pre_locked", 32'(locked), 1);
        run_to(496);
        chk("B_drop", 32'(locked), 0);
        chk("B_err", 32'(err_cnt), 1);
        chk("B_line_len", 32'(line_len), 18);
        run_to(920);
        chk("B_relock_early", 32'(locked), 0);
        run_to(921);
        chk("B_relock", 32'(locked), 1);
        chk("B_relock_err", 32'(err_cnt), 1);

        // Reset mid-frame while locked, with pix_en high on the same edge
        run_to(930);
        @(negedge clk_50);
        rst = 1'b1; pix_en = 1'b1; hs_in = 1'b0;
        @(negedge clk_50);
        rst = 1'b0; pix_en = 1'b0; hs_in = 1'b1;
        chk("C_locked", 32'(locked), 0);
        chk("C_pixel_x", 32'(pixel_x), 0);
        chk("C_pixel_y", 32'(pixel_y), 0);
        chk("C_in_disp", 32'(in_display_area), 0);
        chk("C_line_len", 32'(line_len), 0);
        chk("C_frame_lines", 32'(frame_lines), 0);
        chk("C_err_cnt", 32'(err_cnt), 0);
        sh = 0; sv = 0; tick_n = 0; ht_len = HT; vt_len = VT;

        // Short (8-line) frame during VERIFY delays lock to tick 596
        run_to(153);
        vt_len = 8;
        run_to(290);
        chk("D_frame_lines_9", 32'(frame_lines), 9);
        run_to(291);
        chk("D_frame_lines_8", 32'(frame_lines), 8);
        chk("D_not_locked", 32'(locked), 0);
        run_to(308);
        chk("D_no_early_lock", 32'(locked), 0);
        run_to(596);
        chk("D_prelock", 32'(locked), 0);
        run_to(597);
        chk("D_lock", 32'(locked), 1);
        chk("D_err", 32'(err_cnt), 0);

        // hsync held high while locked
        run_to(612);
        hs_force = 1'b1;
        run_to(614);
        chk("E_pre_drop", 32'(locked), 1);
        run_to(615);
        chk("E_drop", 32'(locked), 0);
        chk("E_err", 32'(err_cnt), 1);
        run_to(2720);
        hs_force = 1'b0;
        chk("E_line_len_held", 32'(line_len), 17);
        run_to(2722);
        chk("E_h_saturate", 32'(line_len), 2047);
        chk("E_err_once", 32'(err_cnt), 1);
        chk("E_unlocked", 32'(locked), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
